d_mem_responder: RTL and testbench

D_MEM_RESPONDER -- requirements
Module: d_mem_responder

---
 rtl/d_mem_responder_if.sv | 21 ++
 rtl/d_mem_responder.sv | 105 ++++++++++
 tb/tb_d_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_mem_responder_if.sv
// Core-side data-memory bus: request/command/address/data from the core, data and ready back.
interface d_mem_responder_if;
   logic        d_mem_assert;
   logic        d_mem_cmd;
   logic        d_mem_be0;
   logic        d_mem_be1;
   logic [15:0] d_mem_addr;
   logic [15:0] d_mem_data_out;
   logic [15:0] d_mem_data_in;
   logic        d_mem_rdy;

   modport master (
      output d_mem_assert, d_mem_cmd, d_mem_be0, d_mem_be1, d_mem_addr, d_mem_data_out,
      input  d_mem_data_in, d_mem_rdy
   );

   modport slave (
      input  d_mem_assert, d_mem_cmd, d_mem_be0, d_mem_be1, d_mem_addr, d_mem_data_out,
      output d_mem_data_in, d_mem_rdy
   );
endinterface

// File: rtl/d_mem_responder.sv
// Byte-lane data memory with programmable wait states; a write to 16'hFFFE raises a sticky halt.
module d_mem_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              a_rst,
   d_mem_responder_if.slave  bus,
   output logic              halt
);

   localparam int DEPTH = 2 ** (ADDR_BITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        cmd_q;
   logic        be0_q;
   logic        be1_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic [15:0] read_val;

   logic [7:0] mem_even [DEPTH];
   logic [7:0] mem_odd  [DEPTH];

   logic [ADDR_BITS-2:0] idx;
   logic                 word;

   assign idx  = addr_q[ADDR_BITS-1:1];
   assign word = be0_q & be1_q;

   // Big-endian lanes: even byte is the high half of a word.
   always_comb begin
      read_val = 16'h0000;
      if (word)
         read_val = {mem_even[idx], mem_odd[idx]};
      else if (addr_q[0])
         read_val = {8'h00, mem_odd[idx]};
      else
         read_val = {8'h00, mem_even[idx]};
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         cmd_q   <= 1'b0;
         be0_q   <= 1'b0;
         be1_q   <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         halt    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.d_mem_assert) begin
                  cmd_q   <= bus.d_mem_cmd;
                  be0_q   <= bus.d_mem_be0;
                  be1_q   <= bus.d_mem_be1;
                  addr_q  <= bus.d_mem_addr;
                  wdata_q <= bus.d_mem_data_out;
                  cnt     <= 4'(WAIT_STATES);
                  state   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            S_RESP: begin
               state <= S_IDLE;
               if (!cmd_q) rdata_q <= read_val;
               if (cmd_q && addr_q == 16'hFFFE) halt <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: the arrays are deliberately left out of reset so they map onto RAM and survive a_rst.
   always_ff @(posedge clk) begin
      if (state == S_RESP && cmd_q) begin
         if (word) begin
            mem_even[idx] <= wdata_q[15:8];
            mem_odd[idx]  <= wdata_q[7:0];
         end else if (addr_q[0]) begin
            mem_odd[idx]  <= wdata_q[7:0];
         end else begin
            mem_even[idx] <= wdata_q[7:0];
         end
      end
   end

   // Read data is live during the ready cycle and then held until the next read completes.
   assign bus.d_mem_rdy     = (state == S_RESP);
   assign bus.d_mem_data_in = (state == S_RESP && !cmd_q) ? read_val : rdata_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// Directed bench: WAIT_STATES=1 instance for most scenarios, WAIT_STATES=0 instance for back-to-back.
module tb_d_mem_responder;

   logic clk = 1'b0;
   logic a_rst;
   logic halt1;
   logic halt0;
   int   checks = 0;
   int   errors = 0;

   d_mem_responder_if bus1 ();
   d_mem_responder_if bus0 ();

   d_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(1)) dut1 (
      .clk(clk), .a_rst(a_rst), .bus(bus1), .halt(halt1)
   );

   d_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
      .clk(clk), .a_rst(a_rst), .bus(bus0), .halt(halt0)
   );

   always #5 clk = ~clk;

   // Caller is at a negedge; returns at a negedge with the request finished.
   task automatic req(input logic cmd, input logic be0, input logic be1,
                      input logic [15:0] addr, input logic [15:0] wdata, input bit corrupt,
                      output logic [15:0] rdata, output int lat);
      bus1.d_mem_assert   = 1'b1;
      bus1.d_mem_cmd      = cmd;
      bus1.d_mem_be0      = be0;
      bus1.d_mem_be1      = be1;
      bus1.d_mem_addr     = addr;
      bus1.d_mem_data_out = wdata;
      @(posedge clk);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (corrupt && i == 1) begin
            bus1.d_mem_cmd      = ~cmd;
            bus1.d_mem_be0      = ~be0;
            bus1.d_mem_addr     = addr ^ 16'h0030;
            bus1.d_mem_data_out = ~wdata;
         end
         if (bus1.d_mem_rdy) begin
            lat = i;
            break;
         end
      end
      rdata = bus1.d_mem_data_in;
      bus1.d_mem_assert = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      a_rst = 1'b0;
      bus1.d_mem_assert   = 1'b1;
      bus1.d_mem_cmd      = 1'b1;
      bus1.d_mem_be0      = 1'b1;
      bus1.d_mem_be1      = 1'b1;
      bus1.d_mem_addr     = 16'hFFFE;
      bus1.d_mem_data_out = 16'hBEEF;
      repeat (3) @(negedge clk);
      checks++;
      if (bus1.d_mem_rdy !== 1'b0) begin
         errors++; $display("FAIL reset_rdy got %b want 0", bus1.d_mem_rdy);
      end
      checks++;
      if (bus1.d_mem_data_in !== 16'h0000) begin
         errors++; $display("FAIL reset_data got %h want 0000", bus1.d_mem_data_in);
      end
      checks++;
      if (halt1 !== 1'b0) begin
         errors++; $display("FAIL reset_halt got %b want 0", halt1);
      end
      bus1.d_mem_assert = 1'b0;
   endtask

   task automatic test_word();
      logic [15:0] rd;
      int lat;
      a_rst = 1'b1;
      req(1'b1, 1'b1, 1'b1, 16'h00A0, 16'hC000, 1'b0, rd, lat);
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL first_accept_latency got %0d want 2", lat);
      end
      req(1'b0, 1'b1, 1'b1, 16'h00A0, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL word_read_latency got %0d want 2", lat);
      end
      checks++;
      if (rd !== 16'hC000) begin
         errors++; $display("FAIL word_read got %h want C000", rd);
      end
   endtask

   task automatic test_byte();
      logic [15:0] rd;
      int lat;
      req(1'b1, 1'b1, 1'b1, 16'h00A2, 16'h3456, 1'b0, rd, lat);
      req(1'b1, 1'b0, 1'b1, 16'h00A3, 16'h12AB, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'hC000 || bus1.d_mem_data_in !== 16'hC000) begin
         errors++; $display("FAIL data_held_over_write got %h/%h want C000", rd, bus1.d_mem_data_in);
      end
      req(1'b0, 1'b1, 1'b1, 16'h00A2, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h34AB) begin
         errors++; $display("FAIL word_after_byte got %h want 34AB", rd);
      end
      req(1'b0, 1'b0, 1'b1, 16'h00A3, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h00AB) begin
         errors++; $display("FAIL byte_read_odd got %h want 00AB", rd);
      end
      req(1'b0, 1'b1, 1'b0, 16'h00A2, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h0034) begin
         errors++; $display("FAIL byte_read_even got %h want 0034", rd);
      end
      req(1'b0, 1'b1, 1'b1, 16'h00A3, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h34AB) begin
         errors++; $display("FAIL word_read_unaligned got %h want 34AB", rd);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] rd;
      int lat;
      req(1'b1, 1'b1, 1'b1, 16'h1010, 16'h5555, 1'b0, rd, lat);
      req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h5555) begin
         errors++; $display("FAIL wrap_read got %h want 5555", rd);
      end
   endtask

   task automatic test_capture();
      logic [15:0] rd;
      int lat;
      req(1'b1, 1'b1, 1'b1, 16'h0060, 16'h2222, 1'b0, rd, lat);
      req(1'b1, 1'b1, 1'b1, 16'h0050, 16'h1111, 1'b1, rd, lat);
      req(1'b0, 1'b1, 1'b1, 16'h0050, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h1111) begin
         errors++; $display("FAIL capture_target got %h want 1111", rd);
      end
      req(1'b0, 1'b1, 1'b1, 16'h0060, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h2222) begin
         errors++; $display("FAIL capture_bystander got %h want 2222", rd);
      end
   endtask

   task automatic test_halt();
      logic [15:0] rd;
      int lat;
      req(1'b1, 1'b1, 1'b0, 16'h0FFE, 16'h0077, 1'b0, rd, lat);
      checks++;
      if (halt1 !== 1'b0) begin
         errors++; $display("FAIL halt_alias_only got %b want 0", halt1);
      end
      req(1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h0099, 1'b0, rd, lat);
      checks++;
      if (halt1 !== 1'b1) begin
         errors++; $display("FAIL halt_set got %b want 1", halt1);
      end
      req(1'b0, 1'b1, 1'b0, 16'h0FFE, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'h0099) begin
         errors++; $display("FAIL halt_write_aliased got %h want 0099", rd);
      end
      checks++;
      if (halt1 !== 1'b1) begin
         errors++; $display("FAIL halt_sticky got %b want 1", halt1);
      end
      a_rst = 1'b0;
      @(negedge clk);
      checks++;
      if (halt1 !== 1'b0) begin
         errors++; $display("FAIL halt_cleared got %b want 0", halt1);
      end
      a_rst = 1'b1;
      req(1'b0, 1'b1, 1'b1, 16'h00A0, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'hC000) begin
         errors++; $display("FAIL mem_kept_over_reset got %h want C000", rd);
      end
   endtask

   task automatic test_abort();
      logic [15:0] rd;
      int lat;
      bit seen;
      req(1'b1, 1'b1, 1'b1, 16'h0040, 16'hABCD, 1'b0, rd, lat);
      bus1.d_mem_assert   = 1'b1;
      bus1.d_mem_cmd      = 1'b1;
      bus1.d_mem_be0      = 1'b1;
      bus1.d_mem_be1      = 1'b1;
      bus1.d_mem_addr     = 16'h0040;
      bus1.d_mem_data_out = 16'hDEAD;
      @(posedge clk);
      @(negedge clk);
      a_rst = 1'b0;
      bus1.d_mem_assert = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      if (bus1.d_mem_rdy) seen = 1'b1;
      a_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus1.d_mem_rdy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL abort_no_rdy got %b want 0", seen);
      end
      req(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 16'hABCD) begin
         errors++; $display("FAIL abort_no_write got %h want ABCD", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic        b_cmd  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [15:0] b_addr [5] = '{16'h0100, 16'h0102, 16'h0100, 16'h0102, 16'h0100};
      logic [15:0] b_data [5] = '{16'h1111, 16'h2222, 16'h1111, 16'h2222, 16'h1111};
      int n    = 0;
      int last = 0;
      bus0.d_mem_assert   = 1'b1;
      bus0.d_mem_be0      = 1'b1;
      bus0.d_mem_be1      = 1'b1;
      bus0.d_mem_cmd      = b_cmd[0];
      bus0.d_mem_addr     = b_addr[0];
      bus0.d_mem_data_out = b_data[0];
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus0.d_mem_rdy) begin
            checks++;
            if (i - last !== ((n == 0) ? 1 : 2)) begin
               errors++; $display("FAIL b2b_spacing req %0d got %0d want %0d", n, i - last, (n == 0) ? 1 : 2);
            end
            if (n < 5 && !b_cmd[n]) begin
               checks++;
               if (bus0.d_mem_data_in !== b_data[n]) begin
                  errors++; $display("FAIL b2b_read req %0d got %h want %h", n, bus0.d_mem_data_in, b_data[n]);
               end
            end
            last = i;
            n++;
            if (n < 5) begin
               bus0.d_mem_cmd      = b_cmd[n];
               bus0.d_mem_addr     = b_addr[n];
               bus0.d_mem_data_out = b_data[n];
            end else begin
               bus0.d_mem_assert = 1'b0;
            end
         end
      end
      checks++;
      if (n !== 5) begin
         errors++; $display("FAIL b2b_count got %0d want 5", n);
      end
   endtask

   initial begin
      a_rst = 1'b0;
      bus1.d_mem_assert = 1'b0; bus1.d_mem_cmd = 1'b0; bus1.d_mem_be0 = 1'b0;
      bus1.d_mem_be1 = 1'b0; bus1.d_mem_addr = 16'h0; bus1.d_mem_data_out = 16'h0;
      bus0.d_mem_assert = 1'b0; bus0.d_mem_cmd = 1'b0; bus0.d_mem_be0 = 1'b0;
      bus0.d_mem_be1 = 1'b0; bus0.d_mem_addr = 16'h0; bus0.d_mem_data_out = 16'h0;
      test_reset();
      test_word();
      test_byte();
      test_wrap();
      test_capture();
      test_halt();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
